axi_master_arbiter: RTL and testbench

AXI_MASTER_ARBITER -- requirements
Module: axi_master_arbiter

---
 rtl/axi_master_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_axi_master_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_arbiter.sv
// Two-requester arbiter driving a single AXI-lite master port, one transaction in flight.
// Define ARB_TIMEOUT_EN to abort slave-wait states after TIMEOUT cycles with RSP_RESP=2'b10.
module axi_master_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        S_ACLK,
  input  logic        S_ARRESET,
  input  logic [1:0]  REQ_VALID,
  input  logic [1:0]  REQ_WRITE,
  input  logic [63:0] REQ_ADDR,
  input  logic [63:0] REQ_WDATA,
  input  logic [7:0]  REQ_WSTRB,
  output logic [1:0]  REQ_ACK,
  output logic [1:0]  RSP_VALID,
  output logic [31:0] RSP_DATA,
  output logic [1:0]  RSP_RESP,
  output logic        M_AWVALID,
  output logic [31:0] M_AWADDR,
  input  logic        S_AWREADY,
  output logic        M_WVALID,
  output logic [31:0] M_WDATA,
  output logic [3:0]  M_WSTRB,
  input  logic        S_WREADY,
  input  logic        S_BVALID,
  input  logic [1:0]  S_BRESP,
  output logic        M_BREADY,
  output logic        M_ARVALID,
  output logic [31:0] M_ARADDR,
  output logic [3:0]  M_BLEN,
  input  logic        S_ARREADY,
  input  logic        S_RVALID,
  input  logic [31:0] S_RDATA,
  output logic        M_RREADY
);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

  state_t      state;
  logic        last_grant;
  logic        grant;
  logic        aw_done;
  logic        w_done;
  logic        ar_done;
  logic        next_grant;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_strb;
  logic [1:0]  grant_mask;

  // A tie goes to whichever requester was not served last.
  always_comb begin
    next_grant = 1'b0;
    case (REQ_VALID)
      2'b01:   next_grant = 1'b0;
      2'b10:   next_grant = 1'b1;
      2'b11:   next_grant = ~last_grant;
      default: next_grant = 1'b0;
    endcase
  end

  assign sel_addr   = next_grant ? REQ_ADDR[63:32]  : REQ_ADDR[31:0];
  assign sel_wdata  = next_grant ? REQ_WDATA[63:32] : REQ_WDATA[31:0];
  assign sel_strb   = next_grant ? REQ_WSTRB[7:4]   : REQ_WSTRB[3:0];
  assign grant_mask = grant ? 2'b10 : 2'b01;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wait_cnt;
  logic        restart;

  // The counter restarts whenever the next state is a fresh wait phase (or no wait at all).
  assign restart = (state == IDLE) || (state == DONE) ||
                   ((state == WR_ADDR) && aw_done && w_done) ||
                   ((state == RD_ADDR) && ar_done);
`else
  logic timeout_unused;
  assign timeout_unused = ^16'(TIMEOUT);
`endif

  always_ff @(posedge S_ACLK) begin
    if (S_ARRESET) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      ar_done    <= 1'b0;
      REQ_ACK    <= '0;
      RSP_VALID  <= '0;
      RSP_DATA   <= '0;
      RSP_RESP   <= '0;
      M_AWVALID  <= 1'b0;
      M_AWADDR   <= '0;
      M_WVALID   <= 1'b0;
      M_WDATA    <= '0;
      M_WSTRB    <= '0;
      M_BREADY   <= 1'b0;
      M_ARVALID  <= 1'b0;
      M_ARADDR   <= '0;
      M_BLEN     <= '0;
      M_RREADY   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      REQ_ACK   <= '0;
      RSP_VALID <= '0;
      case (state)
        IDLE: begin
          if (|REQ_VALID) begin
            grant      <= next_grant;
            last_grant <= next_grant;
            REQ_ACK    <= next_grant ? 2'b10 : 2'b01;
            if (REQ_WRITE[next_grant]) begin
              state     <= WR_ADDR;
              M_AWVALID <= 1'b1;
              M_WVALID  <= 1'b1;
              M_AWADDR  <= sel_addr;
              M_WDATA   <= sel_wdata;
              M_WSTRB   <= sel_strb;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
            end else begin
              state     <= RD_ADDR;
              M_ARVALID <= 1'b1;
              M_ARADDR  <= sel_addr;
              M_BLEN    <= sel_strb;
              ar_done   <= 1'b0;
            end
          end
        end
        // AW and W complete independently; the response phase starts once both are recorded.
        WR_ADDR: begin
          if (aw_done && w_done) begin
            state    <= WR_RESP;
            M_BREADY <= 1'b1;
          end else begin
            if (M_AWVALID && S_AWREADY) begin
              M_AWVALID <= 1'b0;
              aw_done   <= 1'b1;
            end
            if (M_WVALID && S_WREADY) begin
              M_WVALID <= 1'b0;
              w_done   <= 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (S_BVALID) begin
            M_BREADY  <= 1'b0;
            state     <= DONE;
            RSP_VALID <= grant_mask;
            RSP_RESP  <= S_BRESP;
            RSP_DATA  <= '0;
          end
        end
        RD_ADDR: begin
          if (ar_done) begin
            state    <= RD_DATA;
            M_RREADY <= 1'b1;
          end else if (S_ARREADY) begin
            M_ARVALID <= 1'b0;
            ar_done   <= 1'b1;
          end
        end
        RD_DATA: begin
          if (S_RVALID) begin
            M_RREADY  <= 1'b0;
            state     <= DONE;
            RSP_VALID <= grant_mask;
            RSP_DATA  <= S_RDATA;
            RSP_RESP  <= 2'b00;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef ARB_TIMEOUT_EN
      // An expired wait overrides whatever the state logic chose this cycle.
      wait_cnt <= restart ? 16'd0 : wait_cnt + 16'd1;
      if (!restart && (wait_cnt == TIMEOUT_LAST)) begin
        M_AWVALID <= 1'b0;
        M_WVALID  <= 1'b0;
        M_BREADY  <= 1'b0;
        M_ARVALID <= 1'b0;
        M_RREADY  <= 1'b0;
        state     <= DONE;
        RSP_VALID <= grant_mask;
        RSP_RESP  <= 2'b10;
        RSP_DATA  <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: cycle vector table plus multi-cycle corner sequences.
// Covers the ARB_TIMEOUT_EN abort path when that macro is defined (TIMEOUT=8).
module tb_axi_master_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        S_ACLK;
  logic        S_ARRESET;
  logic [1:0]  REQ_VALID;
  logic [1:0]  REQ_WRITE;
  logic [63:0] REQ_ADDR;
  logic [63:0] REQ_WDATA;
  logic [7:0]  REQ_WSTRB;
  logic [1:0]  REQ_ACK;
  logic [1:0]  RSP_VALID;
  logic [31:0] RSP_DATA;
  logic [1:0]  RSP_RESP;
  logic        M_AWVALID;
  logic [31:0] M_AWADDR;
  logic        S_AWREADY;
  logic        M_WVALID;
  logic [31:0] M_WDATA;
  logic [3:0]  M_WSTRB;
  logic        S_WREADY;
  logic        S_BVALID;
  logic [1:0]  S_BRESP;
  logic        M_BREADY;
  logic        M_ARVALID;
  logic [31:0] M_ARADDR;
  logic [3:0]  M_BLEN;
  logic        S_ARREADY;
  logic        S_RVALID;
  logic [31:0] S_RDATA;
  logic        M_RREADY;

  axi_master_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .S_ACLK(S_ACLK), .S_ARRESET(S_ARRESET),
    .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB), .REQ_ACK(REQ_ACK),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_RESP(RSP_RESP),
    .M_AWVALID(M_AWVALID), .M_AWADDR(M_AWADDR), .S_AWREADY(S_AWREADY),
    .M_WVALID(M_WVALID), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .S_WREADY(S_WREADY),
    .S_BVALID(S_BVALID), .S_BRESP(S_BRESP), .M_BREADY(M_BREADY),
    .M_ARVALID(M_ARVALID), .M_ARADDR(M_ARADDR), .M_BLEN(M_BLEN), .S_ARREADY(S_ARREADY),
    .S_RVALID(S_RVALID), .S_RDATA(S_RDATA), .M_RREADY(M_RREADY)
  );

  typedef struct packed {
    logic        rst;
    logic [1:0]  valid;
    logic [1:0]  write;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [3:0]  strb0;
    logic [3:0]  strb1;
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
  } ins_t;

  typedef struct packed {
    logic [1:0]  ack;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_resp;
    logic        awvalid;
    logic        wvalid;
    logic        bready;
    logic        arvalid;
    logic        rready;
    logic [31:0] rsp_data;
    logic [31:0] awaddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] araddr;
    logic [3:0]  blen;
  } outs_t;

  typedef struct packed {
    ins_t  stim;
    outs_t exp;
  } vec_t;

  localparam logic [31:0] W = 32'hA1B2C3D4;
  localparam logic [31:0] D = 32'h55AA55AA;
  localparam int NVEC = 17;

  outs_t got;
  vec_t  tbl [NVEC];
  int    n_vec;
  int    n_fail;
  int    outstanding;
  int    acks;
  int    pulses;
  int    cnt;
  logic  ok;
  ins_t  cur;
  logic [1:0] exp_order [3];

  assign got = {REQ_ACK, RSP_VALID, RSP_RESP, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID,
                M_RREADY, RSP_DATA, M_AWADDR, M_WDATA, M_WSTRB, M_ARADDR, M_BLEN};

  initial S_ACLK = 1'b0;
  always #5 S_ACLK = ~S_ACLK;

  function automatic ins_t inReq(logic rst, logic [1:0] valid, logic [1:0] write,
                                 logic [31:0] addr, logic [31:0] wdata, logic [3:0] strb,
                                 logic [1:0] bresp);
    ins_t v;
    v = '{rst: rst, valid: valid, write: write, addr0: addr, addr1: addr, wdata0: wdata,
          wdata1: wdata, strb0: strb, strb1: strb, awready: 1'b1, wready: 1'b1,
          bvalid: 1'b1, bresp: bresp, arready: 1'b1, rvalid: 1'b1, rdata: W};
    return v;
  endfunction

  function automatic outs_t outExp(logic [1:0] ack, logic [1:0] rv, logic [1:0] resp,
                                   logic aw, logic w, logic b, logic ar, logic r,
                                   logic [31:0] rdata, logic [31:0] awaddr, logic [31:0] wdata,
                                   logic [3:0] wstrb, logic [31:0] araddr, logic [3:0] blen);
    outs_t o;
    o = '{ack: ack, rsp_valid: rv, rsp_resp: resp, awvalid: aw, wvalid: w, bready: b,
          arvalid: ar, rready: r, rsp_data: rdata, awaddr: awaddr, wdata: wdata,
          wstrb: wstrb, araddr: araddr, blen: blen};
    return o;
  endfunction

  task automatic applyStimulus(input ins_t v);
    S_ARRESET = v.rst;
    REQ_VALID = v.valid;
    REQ_WRITE = v.write;
    REQ_ADDR  = {v.addr1, v.addr0};
    REQ_WDATA = {v.wdata1, v.wdata0};
    REQ_WSTRB = {v.strb1, v.strb0};
    S_AWREADY = v.awready;
    S_WREADY  = v.wready;
    S_BVALID  = v.bvalid;
    S_BRESP   = v.bresp;
    S_ARREADY = v.arready;
    S_RVALID  = v.rvalid;
    S_RDATA   = v.rdata;
  endtask

  task automatic tick();
    @(posedge S_ACLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic waitAck(input int maxc, output logic found);
    found = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      tick();
      if (REQ_ACK != 2'b00) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;

    tbl[0]  = '{inReq(1, 2'b00, 2'b00, 0, 0, 0, 0), outExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{inReq(0, 2'b00, 2'b00, 0, 0, 0, 0), outExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{inReq(0, 2'b01, 2'b01, 32'h4, W, 4'hF, 0),
                outExp(2'b01, 0, 0, 1, 1, 0, 0, 0, 0, 32'h4, W, 4'hF, 0, 0)};
    tbl[3]  = '{inReq(0, 2'b00, 2'b00, 0, 0, 0, 0), outExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, W, 4'hF, 0, 0)};
    tbl[4]  = '{inReq(0, 2'b00, 2'b00, 0, 0, 0, 0), outExp(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h4, W, 4'hF, 0, 0)};
    tbl[5]  = '{inReq(0, 2'b00, 2'b00, 0, 0, 0, 0),
                outExp(0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 32'h4, W, 4'hF, 0, 0)};
    tbl[6]  = '{inReq(0, 2'b00, 2'b00, 0, 0, 0, 0), outExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, W, 4'hF, 0, 0)};
    tbl[7]  = '{inReq(0, 2'b01, 2'b00, 32'h4, 0, 4'hF, 0),
                outExp(2'b01, 0, 0, 0, 0, 0, 1, 0, 0, 32'h4, W, 4'hF, 32'h4, 4'hF)};
    tbl[8]  = '{inReq(0, 2'b00, 2'b00, 0, 0, 0, 0),
                outExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, W, 4'hF, 32'h4, 4'hF)};
    tbl[9]  = '{inReq(0, 2'b00, 2'b00, 0, 0, 0, 0),
                outExp(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h4, W, 4'hF, 32'h4, 4'hF)};
    tbl[10] = '{inReq(0, 2'b00, 2'b00, 0, 0, 0, 0),
                outExp(0, 2'b01, 2'b00, 0, 0, 0, 0, 0, W, 32'h4, W, 4'hF, 32'h4, 4'hF)};
    tbl[11] = '{inReq(0, 2'b00, 2'b00, 0, 0, 0, 0),
                outExp(0, 0, 0, 0, 0, 0, 0, 0, W, 32'h4, W, 4'hF, 32'h4, 4'hF)};
    tbl[12] = '{inReq(0, 2'b10, 2'b10, 32'h10, D, 4'h3, 2'b01),
                outExp(2'b10, 0, 0, 1, 1, 0, 0, 0, W, 32'h10, D, 4'h3, 32'h4, 4'hF)};
    tbl[13] = '{inReq(0, 2'b00, 2'b00, 0, 0, 0, 2'b01),
                outExp(0, 0, 0, 0, 0, 0, 0, 0, W, 32'h10, D, 4'h3, 32'h4, 4'hF)};
    tbl[14] = '{inReq(0, 2'b00, 2'b00, 0, 0, 0, 2'b01),
                outExp(0, 0, 0, 0, 0, 1, 0, 0, W, 32'h10, D, 4'h3, 32'h4, 4'hF)};
    tbl[15] = '{inReq(0, 2'b00, 2'b00, 0, 0, 0, 2'b01),
                outExp(0, 2'b10, 2'b01, 0, 0, 0, 0, 0, 0, 32'h10, D, 4'h3, 32'h4, 4'hF)};
    tbl[16] = '{inReq(0, 2'b00, 2'b00, 0, 0, 0, 2'b01),
                outExp(0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 32'h10, D, 4'h3, 32'h4, 4'hF)};

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(tbl[i].stim);
      tick();
      checkOutput($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Contention: both requesters hold reads; last grant was requester 1, so order is 0,1,0.
    exp_order[0] = 2'b01;
    exp_order[1] = 2'b10;
    exp_order[2] = 2'b01;
    cur = inReq(0, 2'b11, 2'b00, 32'h100, 0, 4'hF, 0);
    cur.addr1 = 32'h200;
    applyStimulus(cur);
    outstanding = 0;
    acks = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (REQ_ACK != 2'b00) begin
        checkField("contention_overlap", outstanding, 0);
        checkField("contention_grant", {30'd0, REQ_ACK}, {30'd0, exp_order[acks]});
        checkField("contention_araddr", M_ARADDR, (exp_order[acks] == 2'b01) ? 32'h100 : 32'h200);
        outstanding++;
        acks++;
        if (acks == 3) begin
          cur.valid = 2'b00;
          applyStimulus(cur);
        end
      end
      if (RSP_VALID != 2'b00) outstanding--;
      if (acks == 3 && outstanding == 0) break;
    end
    checkField("contention_complete", {31'd0, (acks == 3 && outstanding == 0)}, 1);
    tick();

    // Split handshake: AWREADY rises three cycles before WREADY.
    cur = inReq(0, 2'b01, 2'b01, 32'h20, 32'hDEADBEEF, 4'hF, 2'b11);
    cur.awready = 0; cur.wready = 0; cur.bvalid = 0; cur.arready = 0; cur.rvalid = 0;
    applyStimulus(cur);
    waitAck(10, ok);
    checkField("split_ack", {31'd0, ok}, 1);
    cur.valid = 2'b00;
    cur.awready = 1;
    applyStimulus(cur);
    tick();
    checkField("split_aw_drop", {30'd0, M_AWVALID, M_WVALID}, 32'b01);
    tick();
    checkField("split_w_hold1", {31'd0, M_WVALID}, 1);
    tick();
    checkField("split_w_hold2", {31'd0, M_WVALID}, 1);
    cur.wready = 1;
    applyStimulus(cur);
    tick();
    checkField("split_w_drop", {31'd0, M_WVALID}, 0);
    tick();
    checkField("split_bready", {31'd0, M_BREADY}, 1);
    tick();
    checkField("split_bwait", {30'd0, M_BREADY, RSP_VALID[0]}, 32'b10);
    cur.bvalid = 1;
    applyStimulus(cur);
    tick();
    checkField("split_rsp", {26'd0, RSP_VALID, RSP_RESP, M_BREADY, M_WVALID}, {26'd0, 2'b01, 2'b11, 2'b00});
    cur.bvalid = 0;
    applyStimulus(cur);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (RSP_VALID != 2'b00 || M_BREADY) pulses++;
    end
    checkField("split_single_b", pulses, 0);

    // Reset while waiting for read data abandons the transaction.
    cur = inReq(0, 2'b10, 2'b00, 32'h30, 0, 4'hF, 0);
    cur.rvalid = 0;
    applyStimulus(cur);
    waitAck(10, ok);
    checkField("rst_ack", {30'd0, REQ_ACK}, {30'd0, 2'b10});
    cur.valid = 2'b00;
    applyStimulus(cur);
    tick();
    tick();
    checkField("rst_rd_data", {31'd0, M_RREADY}, 1);
    cur.rst = 1;
    cur.rvalid = 1;
    cur.rdata = 32'h12345678;
    applyStimulus(cur);
    tick();
    checkOutput("rst_all_zero", '0);
    cur.rst = 0;
    applyStimulus(cur);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (RSP_VALID != 2'b00) pulses++;
    end
    checkField("rst_no_rsp", pulses, 0);
    cur = inReq(0, 2'b11, 2'b11, 32'h40, 32'hCAFEF00D, 4'hF, 0);
    cur.addr1 = 32'h50;
    applyStimulus(cur);
    tick();
    checkField("rst_after_ack", {30'd0, REQ_ACK}, {30'd0, 2'b01});
    checkField("rst_after_awaddr", M_AWADDR, 32'h40);
    cur.valid = 2'b00;
    applyStimulus(cur);
    tick();
    tick();
    checkField("rst_after_not_yet", {30'd0, RSP_VALID}, 0);
    tick();
    checkField("rst_after_rsp", {28'd0, RSP_VALID, RSP_RESP}, {28'd0, 2'b01, 2'b00});
    tick();

`ifdef ARB_TIMEOUT_EN
    // Slave never accepts the read address: expect an abort after 8 cycles of ARVALID.
    cur = inReq(0, 2'b01, 2'b00, 32'h60, 0, 4'hF, 0);
    cur.arready = 0;
    cur.rvalid = 0;
    applyStimulus(cur);
    waitAck(10, ok);
    checkField("to_ack", {31'd0, ok}, 1);
    cur.valid = 2'b00;
    applyStimulus(cur);
    cnt = 1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (M_ARVALID) cnt++;
      else break;
    end
    checkField("to_arvalid_cycles", cnt, 8);
    checkField("to_rsp", {26'd0, RSP_VALID, RSP_RESP, M_ARVALID, M_RREADY}, {26'd0, 2'b01, 2'b10, 2'b00});
    checkField("to_rsp_data", RSP_DATA, 0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
